if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/rv_fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/if_prefetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-unit constants and the prefetch buffer entry type.
// Used by if_prefetch and fetch_fifo.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int DEPTH_DEF = 4;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x {pc,instr} FIFO with flush; one push and one pop per cycle.
// Ports: clk, rst_ni, flush_i, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  output fetch_entry_t  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues in-order fetches, buffers responses, handles redirects.
// Ports: clk/rst, redirect_*, imem_req_*, imem_rsp_*, instr_* (valid/ready to decode).
module if_prefetch
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_rdata, fifo_wdata;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_drop, rsp_push, pop;

  // Buffered plus in-flight never exceeds DEPTH, so every
  // accepted response is guaranteed a free slot.
  assign in_use = {1'b0, fifo_cnt} + {1'b0, outst_q};

  assign imem_req_valid = rst & ~redirect_valid
                        & (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid
                  & (redirect_valid | (drop_q != '0));
  assign rsp_push = imem_rsp_valid & ~rsp_drop
                  & (~fifo_full | pop);

  assign instr_valid = rst & ~fifo_empty;
  assign pop         = instr_valid & instr_ready & ~redirect_valid;

  assign instr_data = instr_valid ? fifo_rdata.instr : '0;
  assign instr_pc   = instr_valid ? fifo_rdata.pc : RESET_PC;

  assign fifo_wdata.pc    = rsp_pc_q;
  assign fifo_wdata.instr = imem_rsp_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    unique case ({req_fire, imem_rsp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = (outst_q != '0) ? outst_q - CW'(1) : '0;
      default: outst_d = outst_q;
    endcase
    if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
    if (rsp_push) rsp_pc_d = rsp_pc_q + PC_INC;
    if (imem_rsp_valid && !redirect_valid && drop_q != '0)
      drop_d = drop_q - CW'(1);
    // Everything still in flight after this cycle is stale.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
